// File: rtl/read_buffer_burst_pkg.sv
// Shared types and default parameter constants for the read-buffer burst mover.
package read_buffer_burst_pkg;

  localparam int unsigned DATA_W_DEF      = 16;
  localparam int unsigned DEPTH_DEF       = 16;
  localparam int unsigned LEN_W_DEF       = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_SPACE = 3'd1,
    ST_READ_REQ   = 3'd2,
    ST_DO_WRITE   = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

endpackage

// File: rtl/wrap_addr_counter.sv
// Loadable address counter that wraps from DEPTH-1 back to 0 (DEPTH need not be a power of two).
module wrap_addr_counter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (i_clr) begin
      r_addr <= '0;
    end else if (i_load) begin
      r_addr <= i_load_val;
    end else if (i_inc) begin
      r_addr <= (r_addr == LAST) ? '0 : r_addr + 1'b1;
    end
  end

  assign o_addr = r_addr;

endmodule

// File: rtl/read_buffer_burst_ctrl.sv
// Burst mover from the input read buffer into consecutive scratchpad addresses.
// Optional wait timeout enabled by defining READ_BUFFER_BURST_TIMEOUT_EN.
module read_buffer_burst_ctrl
  import read_buffer_burst_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = DEPTH_DEF,
  parameter int unsigned ADDR_W      = $clog2(DEPTH),
  parameter int unsigned LEN_W       = LEN_W_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inner_rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              scratch_write_en,
  input  logic              buf_valid,
  input  logic [DATA_W-1:0] buf_data,
  output logic              write_req_scratch,
  output logic              read_req_buffer,
  output logic              write_in_scratch,
  output logic [ADDR_W-1:0] scratch_addr,
  output logic [DATA_W-1:0] scratch_data,
  output logic              cnt,
  output logic [LEN_W-1:0]  words_done,
  output logic              busy,
  output logic              done,
  output logic              timeout
);

  state_t            r_state, w_next;
  logic              w_rst;
  logic              w_start_burst;
  logic              w_tmo;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_words_done;
  logic [LEN_W-1:0]  w_words_inc;
  logic [DATA_W-1:0] r_data;

  assign w_rst         = rst | inner_rst;
  assign w_start_burst = (r_state == ST_IDLE) && start && (len != '0);
  assign w_words_inc   = r_words_done + 1'b1;

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:       if (start) w_next = (len != '0) ? ST_WAIT_SPACE : ST_DONE;
      ST_WAIT_SPACE: begin
        if (scratch_write_en) w_next = ST_READ_REQ;
        else if (w_tmo)       w_next = ST_IDLE;
      end
      ST_READ_REQ: begin
        if (buf_valid)  w_next = ST_DO_WRITE;
        else if (w_tmo) w_next = ST_IDLE;
      end
      ST_DO_WRITE:   w_next = (w_words_inc == r_len) ? ST_DONE : ST_WAIT_SPACE;
      ST_DONE:       w_next = ST_IDLE;
      default:       w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_len        <= '0;
      r_words_done <= '0;
      r_data       <= '0;
    end else begin
      if (w_start_burst) begin
        r_len        <= len;
        r_words_done <= '0;
      end
      if ((r_state == ST_READ_REQ) && buf_valid) r_data <= buf_data;
      if (r_state == ST_DO_WRITE) r_words_done <= w_words_inc;
    end
  end

  wrap_addr_counter #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_addr (
    .clk        (clk),
    .i_clr      (w_rst),
    .i_load     (w_start_burst),
    .i_load_val (base_addr),
    .i_inc      (r_state == ST_DO_WRITE),
    .o_addr     (scratch_addr)
  );

`ifdef READ_BUFFER_BURST_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_waiting;
  logic             w_exit;

  assign w_waiting = (r_state == ST_WAIT_SPACE) || (r_state == ST_READ_REQ);
  assign w_exit    = ((r_state == ST_WAIT_SPACE) && scratch_write_en) ||
                     ((r_state == ST_READ_REQ) && buf_valid);
  // Count holds the number of full cycles already spent in the current wait state.
  assign w_tmo     = w_waiting && !w_exit && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (w_rst || !w_waiting || (w_next != r_state)) r_tmo_cnt <= '0;
    else                                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign write_req_scratch = (r_state == ST_WAIT_SPACE);
  assign read_req_buffer   = (r_state == ST_READ_REQ);
  assign write_in_scratch  = (r_state == ST_DO_WRITE);
  assign cnt               = (r_state == ST_DO_WRITE);
  assign busy              = (r_state != ST_IDLE);
  assign done              = (r_state == ST_DONE);
  assign timeout           = w_tmo;
  assign words_done        = r_words_done;
  assign scratch_data      = r_data;

endmodule

// File: tb/tb_read_buffer_burst_ctrl.sv
// Directed bench for read_buffer_burst_ctrl: DEPTH=16 and DEPTH=5 instances share stimulus.
// Timeout scenario runs only when READ_BUFFER_BURST_TIMEOUT_EN is defined.
module tb_read_buffer_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst, inner_rst, start, swe, bv;
  logic [7:0]  len;
  logic [3:0]  base16;
  logic [2:0]  base5;
  logic [15:0] bdata;

  logic        wreq, rreq, wr, cnt, busy, done, tmo;
  logic [3:0]  addr16;
  logic [15:0] sdata;
  logic [7:0]  wdone;

  logic        d5_wreq, d5_rreq, d5_wr, d5_cnt, d5_busy, d5_done, d5_tmo;
  logic [2:0]  addr5;
  logic [15:0] d5_sdata;
  logic [7:0]  d5_wdone;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  read_buffer_burst_ctrl #(
    .DATA_W (16), .DEPTH (16), .LEN_W (8), .TIMEOUT_CYC (10)
  ) dut (
    .clk (clk), .rst (rst), .inner_rst (inner_rst), .start (start), .len (len),
    .base_addr (base16), .scratch_write_en (swe), .buf_valid (bv), .buf_data (bdata),
    .write_req_scratch (wreq), .read_req_buffer (rreq), .write_in_scratch (wr),
    .scratch_addr (addr16), .scratch_data (sdata), .cnt (cnt), .words_done (wdone),
    .busy (busy), .done (done), .timeout (tmo)
  );

  read_buffer_burst_ctrl #(
    .DATA_W (16), .DEPTH (5), .LEN_W (8)
  ) dut5 (
    .clk (clk), .rst (rst), .inner_rst (inner_rst), .start (start), .len (len),
    .base_addr (base5), .scratch_write_en (swe), .buf_valid (bv), .buf_data (bdata),
    .write_req_scratch (d5_wreq), .read_req_buffer (d5_rreq), .write_in_scratch (d5_wr),
    .scratch_addr (addr5), .scratch_data (d5_sdata), .cnt (d5_cnt), .words_done (d5_wdone),
    .busy (d5_busy), .done (d5_done), .timeout (d5_tmo)
  );

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-speed burst: cycle k after start is WAIT_SPACE/READ_REQ/DO_WRITE by (k-1)%3, DONE at 3n+1.
  task automatic run_fast(input int unsigned n, input logic [3:0] b16, input logic [2:0] b5,
                          input logic [15:0] d0);
    int unsigned pulses = 0;
    swe = 1'b1; bv = 1'b1; len = 8'(n); base16 = b16; base5 = b5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; len = 8'd9; base16 = 4'hF; base5 = 3'd3;
    for (int unsigned k = 1; k <= 3 * n + 1; k++) begin
      int unsigned w  = (k - 1) / 3;
      int unsigned ph = (k - 1) % 3;
      logic        last = (k == 3 * n + 1);
      bdata = d0 + 16'(w);
      chk("busy", 32'(busy), 1);
      chk("wreq", 32'(wreq), 32'(!last && ph == 0));
      chk("rreq", 32'(rreq), 32'(!last && ph == 1));
      chk("wr",   32'(wr),   32'(!last && ph == 2));
      chk("done", 32'(done), 32'(last));
      if (!last && ph == 2) begin
        chk("addr16", 32'(addr16), (32'(b16) + w) % 16);
        chk("addr5",  32'(addr5),  (32'(b5) + w) % 5);
        chk("sdata",  32'(sdata),  32'(d0) + w);
        chk("wdone_mid", 32'(wdone), w);
      end
      if (cnt) pulses++;
      @(negedge clk);
    end
    chk("busy_end", 32'(busy), 0);
    chk("done_end", 32'(done), 0);
    chk("wdone_end", 32'(wdone), n);
    chk("cnt_pulses", pulses, n);
  endtask

  initial begin
    int unsigned writes;
    rst = 1'b1; inner_rst = 1'b0; start = 1'b0; swe = 1'b0; bv = 1'b0;
    len = '0; base16 = '0; base5 = '0; bdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ctrl", 32'({wreq, rreq, wr, cnt, done, tmo}), 0);
    chk("rst_wdone", 32'(wdone), 0);
    chk("rst_addr", 32'(addr16), 0);
    chk("rst_data", 32'(sdata), 0);
    chk("rst_busy5", 32'(d5_busy), 0);

    // len=3 base=2: addrs 2,3,4 on both depths; done at cycle 10 after start
    run_fast(3, 4'd2, 3'd2, 16'h00A1);
    // wrap: DEPTH=16 gives 4,5,6 while DEPTH=5 gives 4,0,1
    run_fast(3, 4'd4, 3'd4, 16'h0B10);

    // buf_valid low for 6 READ_REQ cycles, start pulsed mid-burst must be ignored
    swe = 1'b1; bv = 1'b0; len = 8'd1; base16 = 4'd7; base5 = 3'd0; bdata = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0; len = 8'd5;
    chk("stall_wreq", 32'(wreq), 1);
    @(negedge clk);
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      start = (i == 0);
      chk("stall_rreq", 32'(rreq), 1);
      chk("stall_tmo", 32'(tmo), 0);
      if (wr) writes++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("stall_rreq7", 32'(rreq), 1);
    bv = 1'b1; bdata = 16'h005A;
    @(negedge clk);
    bv = 1'b0; bdata = 16'hFFFF;
    chk("stall_wr", 32'(wr), 1);
    chk("stall_rreq_off", 32'(rreq), 0);
    chk("stall_addr", 32'(addr16), 7);
    chk("stall_data", 32'(sdata), 16'h005A);
    if (wr) writes++;
    @(negedge clk);
    chk("stall_done", 32'(done), 1);
    if (wr) writes++;
    @(negedge clk);
    chk("stall_idle", 32'(busy), 0);
    chk("stall_writes", writes, 1);
    chk("stall_wdone", 32'(wdone), 1);

    // len=0: DONE right after start, words_done untouched
    len = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done", 32'(done), 1);
    chk("len0_busy", 32'(busy), 1);
    chk("len0_noreq", 32'({wreq, rreq, wr}), 0);
    chk("len0_wdone", 32'(wdone), 1);
    @(negedge clk);
    chk("len0_done_off", 32'(done), 0);
    chk("len0_idle", 32'(busy), 0);

    // inner_rst during READ_REQ of word 3 of 4 with a valid word present
    swe = 1'b1; bv = 1'b1; len = 8'd4; base16 = 4'd0; base5 = 3'd0; bdata = 16'h00C0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("irst_wdone2", 32'(wdone), 2);
    @(negedge clk);
    chk("irst_rreq", 32'(rreq), 1);
    inner_rst = 1'b1; bdata = 16'h00EE;
    @(negedge clk);
    inner_rst = 1'b0;
    chk("irst_busy", 32'(busy), 0);
    chk("irst_ctrl", 32'({wreq, rreq, wr, cnt, done}), 0);
    chk("irst_wdone", 32'(wdone), 0);
    chk("irst_addr", 32'(addr16), 0);
    chk("irst_data", 32'(sdata), 0);
    for (int i = 0; i < 5; i++) begin
      chk("irst_no_done", 32'({done, busy}), 0);
      @(negedge clk);
    end

`ifdef READ_BUFFER_BURST_TIMEOUT_EN
    // TIMEOUT_CYC=10 with no buffer data: pulse on the 10th READ_REQ cycle
    swe = 1'b1; bv = 1'b0; len = 8'd2; base16 = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("tmo_wreq", 32'(wreq), 1);
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      chk("tmo_rreq", 32'(rreq), 1);
      chk("tmo_pulse", 32'(tmo), 32'(i == 10));
      @(negedge clk);
    end
    chk("tmo_idle", 32'(busy), 0);
    chk("tmo_off", 32'(tmo), 0);
    chk("tmo_no_done", 32'(done), 0);
    chk("tmo_wdone", 32'(wdone), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
